write_ctrl: RTL and testbench

//   Write-domain pointer/flag controller for the asynchronous FIFO; counterpart of the read-side controller.

---
 rtl/write_ctrl_if.sv | 35 +++
 rtl/write_ctrl.sv | 78 +++++++
 tb/tb_write_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/write_ctrl_if.sv
// write_ctrl_if: producer/RAM/synchroniser-side bundle of the async FIFO write controller.
//   write_en           producer write request
//   overflow_clr       synchronous clear of sticky overflow
//   read_ptr_gray_sync Gray read pointer, already synchronised into the write clock domain
//   mem_write_en       RAM write strobe
//   write_ptr_binary   RAM write address
//   write_ptr_gray     registered Gray write pointer, goes to the read-domain synchroniser
//   fifo_full, fifo_almost_full, fill_level, overflow   status flags
// Modports: master = environment side (drives requests), slave = write_ctrl.
interface write_ctrl_if #(
   parameter int addr_size = 3
);
   logic                 write_en;
   logic                 overflow_clr;
   logic [addr_size:0]   read_ptr_gray_sync;
   logic                 mem_write_en;
   logic [addr_size-1:0] write_ptr_binary;
   logic [addr_size:0]   write_ptr_gray;
   logic                 fifo_full;
   logic                 fifo_almost_full;
   logic [addr_size:0]   fill_level;
   logic                 overflow;

   modport master (
      output write_en, overflow_clr, read_ptr_gray_sync,
      input  mem_write_en, write_ptr_binary, write_ptr_gray,
             fifo_full, fifo_almost_full, fill_level, overflow
   );

   modport slave (
      input  write_en, overflow_clr, read_ptr_gray_sync,
      output mem_write_en, write_ptr_binary, write_ptr_gray,
             fifo_full, fifo_almost_full, fill_level, overflow
   );
endinterface

// File: rtl/write_ctrl.sv
// write_ctrl: write-domain pointer/flag controller of an asynchronous FIFO.
//   Keeps an extended (addr_size+1 bit) binary write pointer, publishes it as a
//   registered Gray pointer, and derives full / almost-full / fill level from the
//   synchronised Gray read pointer. Overflow is sticky until overflow_clr.
// Ports:
//   write_clk    write-domain clock (rising edge)
//   write_rst_n  asynchronous active-low reset
//   wif          write_ctrl_if.slave bundle (requests in, RAM strobe/address and flags out)
module write_ctrl #(
   parameter int addr_size    = 3,
   parameter int afull_thresh = 6
) (
   input  logic         write_clk,
   input  logic         write_rst_n,
   write_ctrl_if.slave  wif
);
   localparam int A = addr_size;
   localparam logic [A:0] AFULL_TH = (A+1)'(afull_thresh);

   logic [A:0] wb_q, wb_d;
   logic [A:0] wgray_q, wgray_d;
   logic       ovf_q, ovf_d;

   logic [A:0] rgray, rbin, fill;
   logic       full, accept, reject;

   assign rgray = wif.read_ptr_gray_sync;

   // Full when the write pointer has lapped the read pointer exactly once:
   // in Gray form that is the top two bits inverted, the rest equal.
   assign full = (wgray_q == {~rgray[A:A-1], rgray[A-2:0]});

   // Gray -> binary: each bit is the XOR of all Gray bits at and above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= A; i++)
         rbin[i] = ^(rgray >> i);
   end

   // Modulo subtraction; the stale (synchronised) read pointer can only make
   // this an overstatement, which is the safe direction for a writer.
   assign fill   = wb_q - rbin;
   assign accept = wif.write_en & ~full;
   assign reject = wif.write_en &  full;

   always_comb begin
      wb_d    = wb_q;
      ovf_d   = ovf_q;
      if (accept)
         wb_d = wb_q + 1'b1;
      // A reject on the same edge as a clear keeps the flag set.
      if (reject)
         ovf_d = 1'b1;
      else if (wif.overflow_clr)
         ovf_d = 1'b0;
      wgray_d = wb_d ^ (wb_d >> 1);
   end

   always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) begin
         wb_q    <= '0;
         wgray_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wb_q    <= wb_d;
         wgray_q <= wgray_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wif.mem_write_en     = accept;
   assign wif.write_ptr_binary = wb_q[A-1:0];
   assign wif.write_ptr_gray   = wgray_q;
   assign wif.fifo_full        = full;
   assign wif.fifo_almost_full = (fill >= AFULL_TH);
   assign wif.fill_level       = fill;
   assign wif.overflow         = ovf_q;
endmodule

// File: tb/tb_write_ctrl.sv
// tb_write_ctrl: directed scenarios plus a randomized phase for write_ctrl
// (addr_size=3, afull_thresh=6), checked against an occupancy-count model.
module tb_write_ctrl;
   localparam int AS    = 3;
   localparam int DEPTH = 1 << AS;
   localparam int MOD   = 2 * DEPTH;
   localparam int AFT   = 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   write_ctrl_if #(.addr_size(AS)) wif();

   write_ctrl #(.addr_size(AS), .afull_thresh(AFT)) dut (
      .write_clk   (clk),
      .write_rst_n (rst_n),
      .wif         (wif)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: pointers as plain integers mod 2*DEPTH, occupancy by subtraction.
   int m_wb  = 0;
   int m_rd  = 0;
   bit m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int occ();
      return (m_wb - m_rd + MOD) % MOD;
   endfunction

   task automatic check_outputs(input bit we);
      int  o    = occ();
      bit  full = (o == DEPTH);
      chk("mem_write_en", 32'(wif.mem_write_en), 32'(we && !full));
      chk("fifo_full",    32'(wif.fifo_full),    32'(full));
      chk("almost_full",  32'(wif.fifo_almost_full), 32'(o >= AFT));
      chk("fill_level",   32'(wif.fill_level),   32'(o));
      chk("wptr_bin",     32'(wif.write_ptr_binary), 32'(m_wb % DEPTH));
      chk("wptr_gray",    32'(wif.write_ptr_gray), 32'(gray(m_wb)));
      chk("overflow",     32'(wif.overflow),     32'(m_ovf));
   endtask

   // One write-clock cycle: drive at negedge, check before the edge, update model after.
   task automatic step(input bit we, input bit clr, input int rd_new);
      bit acc, rej;
      logic [AS:0] g_prev;
      @(negedge clk);
      m_rd = rd_new % MOD;
      wif.write_en           = we;
      wif.overflow_clr       = clr;
      wif.read_ptr_gray_sync = (AS+1)'(gray(m_rd));
      #1;
      check_outputs(we);
      acc    = we && (occ() != DEPTH);
      rej    = we && (occ() == DEPTH);
      g_prev = wif.write_ptr_gray;
      @(posedge clk);
      #1;
      if (acc) m_wb = (m_wb + 1) % MOD;
      if (rej) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (acc)
         chk("gray_1bit", 32'($countones(g_prev ^ wif.write_ptr_gray)), 32'd1);
   endtask

   // Reset asserted between edges; outputs must clear with no clock edge.
   task automatic do_reset();
      @(negedge clk);
      wif.write_en           = 1'b0;
      wif.overflow_clr       = 1'b0;
      wif.read_ptr_gray_sync = '0;
      rst_n = 1'b0;
      m_wb = 0; m_rd = 0; m_ovf = 1'b0;
      #1;
      chk("rst_gray", 32'(wif.write_ptr_gray), 32'd0);
      chk("rst_bin",  32'(wif.write_ptr_binary), 32'd0);
      chk("rst_ovf",  32'(wif.overflow), 32'd0);
      chk("rst_full", 32'(wif.fifo_full), 32'd0);
      chk("rst_afull", 32'(wif.fifo_almost_full), 32'd0);
      chk("rst_fill", 32'(wif.fill_level), 32'd0);
      wif.write_en = 1'b1;
      #1;
      chk("rst_mwe", 32'(wif.mem_write_en), 32'd1);
      wif.write_en = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n                  = 1'b0;
      wif.write_en           = 1'b0;
      wif.overflow_clr       = 1'b0;
      wif.read_ptr_gray_sync = '0;
      #2;
      rst_n = 1'b1;
      do_reset();

      // Fill from empty: eight accepted writes, then full.
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
      step(0, 0, 0);
      chk("fill8_gray", 32'(wif.write_ptr_gray), 32'b1100);
      chk("fill8_full", 32'(wif.fifo_full), 32'd1);

      // Rejects while full, sticky overflow, clear, and clear-vs-reject.
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      step(1, 1, 0);
      step(0, 0, 0);
      step(0, 1, 0);

      // Read side drains three (one Gray step per cycle), then one more write.
      for (int r = 1; r <= 3; r++) step(0, 0, r);
      step(1, 0, 3);
      step(0, 0, 3);

      // Continuous write with the read pointer trailing by two.
      for (int i = 0; i < 20; i++) step(1, 0, (m_wb - 2 + MOD) % MOD);
      step(0, 0, (m_wb - 2 + MOD) % MOD);

      // Reset mid-operation with overflow set.
      while (occ() != DEPTH) step(1, 0, m_rd);
      step(1, 0, m_rd);
      do_reset();

      // Randomized traffic; the read pointer only advances while the
      // write side sees data, one step per cycle.
      for (int i = 0; i < 400; i++) begin
         int  rn = m_rd;
         bit  we = ($urandom % 4) != 0;
         bit  cl = ($urandom % 8) == 0;
         if (occ() > 0 && ($urandom % 3) == 0) rn = (m_rd + 1) % MOD;
         step(we, cl, rn);
         if (i == 200) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
